// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Shares one Wishbone-style bus between instruction fetch and data memory.
// Optional macro BUS_TIMEOUT_EN enables an abort after TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  // instruction fetch port
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic [DW-1:0]   if_rdata_o,
  output logic            if_ack_o,
  output logic            stallreq_if_o,
  // data memory port
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [DW/8-1:0] mem_sel_i,
  input  logic [AW-1:0]   mem_addr_i,
  input  logic [DW-1:0]   mem_wdata_i,
  output logic [DW-1:0]   mem_rdata_o,
  output logic            mem_ack_o,
  output logic            stallreq_mem_o,
  // external bus
  output logic            bus_cyc_o,
  output logic            bus_stb_o,
  output logic            bus_we_o,
  output logic [DW/8-1:0] bus_sel_o,
  output logic [AW-1:0]   bus_adr_o,
  output logic [DW-1:0]   bus_dat_o,
  input  logic [DW-1:0]   bus_dat_i,
  input  logic            bus_ack_i,
  output logic            bus_err_o
);

  localparam int SW = DW / 8;

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_if_xfer  = 2'd1;
  localparam logic [1:0] c_mem_xfer = 2'd2;
  localparam logic [1:0] c_done     = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          discard_q, discard_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          mem_ack_q, mem_ack_d;
  logic          err_q, err_d;

  logic          w_xfer;
  logic          w_drop_if;
  logic          w_timeout;

  assign w_xfer    = (state_q == c_if_xfer) || (state_q == c_mem_xfer);
  // A flush on the very cycle the slave acks still discards the fetch.
  assign w_drop_if = discard_q | flush_i;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (w_xfer && !bus_ack_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack on the limit cycle wins over the abort.
  assign w_timeout = w_xfer && !bus_ack_i && (cnt_q == c_cnt_last);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      c_idle: begin
        discard_d = 1'b0;
        // MEM belongs to the older instruction, so it always goes first.
        if (mem_req_i) begin
          cyc_d   = 1'b1;
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          adr_d   = mem_addr_i;
          dat_d   = mem_wdata_i;
          state_d = c_mem_xfer;
        end else if (if_req_i) begin
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = '1;
          adr_d   = if_addr_i;
          state_d = c_if_xfer;
        end
      end

      c_if_xfer: begin
        if (flush_i) begin
          discard_d = 1'b1;
        end
        if (bus_ack_i || w_timeout) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = w_timeout;
          state_d = c_done;
          if (!w_drop_if) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_ack_i ? bus_dat_i : '0;
          end
        end
      end

      c_mem_xfer: begin
        if (bus_ack_i || w_timeout) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          err_d       = w_timeout;
          mem_ack_d   = 1'b1;
          mem_rdata_d = bus_ack_i ? bus_dat_i : '0;
          state_d     = c_done;
        end
      end

      c_done: begin
        discard_d = 1'b0;
        state_d   = c_idle;
      end

      default: begin
        state_d = c_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_idle;
      discard_q   <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus_cyc_o      = cyc_q;
  assign bus_stb_o      = cyc_q;
  assign bus_we_o       = we_q;
  assign bus_sel_o      = sel_q;
  assign bus_adr_o      = adr_q;
  assign bus_dat_o      = dat_q;
  assign bus_err_o      = err_q;
  assign if_rdata_o     = if_rdata_q;
  assign if_ack_o       = if_ack_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign mem_ack_o      = mem_ack_q;

  assign stallreq_if_o  = if_req_i & ~if_ack_q & ~flush_i;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_q;

endmodule
`default_nettype wire
